// File: rtl/sc_pkg.sv
// Shared types and constants for the slow-control TX arbiter.
// State encodings, default watchdog limit, requester indices.
package sc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_GAP  = 3'b100
  } state_t;

  localparam logic [15:0] SC_TIMEOUT_DEF = 16'hFFFF;

  localparam int SC_REQ_RXERR  = 0;
  localparam int SC_REQ_RPLY   = 1;
  localparam int SC_REQ_DECERR = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Combinational round-robin picker: first set req bit
// searching upward from ptr+1, wrapping modulo N.
module sc_rr_pick
  import sc_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  int  j;
  logic found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sc_tx_arbiter.sv
// Round-robin owner of the UDP TX port with a hung-source watchdog.
// SC_TXARB_STATS_EN builds the per-source grant counters.
module sc_tx_arbiter
  import sc_pkg::*;
#(
  parameter int               N_REQ   = 3,
  parameter int               TO_W    = 16,
  parameter logic [TO_W-1:0]  TIMEOUT = TO_W'(SC_TIMEOUT_DEF)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      done,
  input  logic [N_REQ-1:0]      start,
  input  logic [8*N_REQ-1:0]    data,
  input  logic [16*N_REQ-1:0]   src_port,
  input  logic [16*N_REQ-1:0]   dst_port,
  input  logic [32*N_REQ-1:0]   dst_ip,
  input  logic [16*N_REQ-1:0]   length,
  output logic [N_REQ-1:0]      grant,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  tx_start,
  output logic                  tx_done,
  output logic                  tx_stop,
  output logic [7:0]            tx_data,
  output logic [15:0]           tx_src_port,
  output logic [15:0]           tx_dst_port,
  output logic [15:0]           tx_length,
  output logic [31:0]           tx_dst_ip,
  output logic                  timeout_pulse,
  output logic [N_REQ-1:0]      timeout_src,
  output logic [7:0]            timeout_count,
  output logic [16*N_REQ-1:0]   grant_count
);

  localparam int              IW      = idx_w(N_REQ);
  localparam bit              WD_EN   = (TIMEOUT != '0);
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  state_t            state, state_d;
  logic [N_REQ-1:0]  grant_d, tsrc_d, pick_oh;
  logic [IW-1:0]     ptr, ptr_d, cur, cur_d, pick_idx;
  logic [TO_W-1:0]   wdog, wdog_d;
  logic              pulse_d;
  logic [7:0]        tcnt_d;

  sc_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_oh),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      grant         <= '0;
      ptr           <= IW'(N_REQ - 1);
      cur           <= '0;
      wdog          <= '0;
      timeout_pulse <= 1'b0;
      timeout_src   <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_d;
      grant         <= grant_d;
      ptr           <= ptr_d;
      cur           <= cur_d;
      wdog          <= wdog_d;
      timeout_pulse <= pulse_d;
      timeout_src   <= tsrc_d;
      timeout_count <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    cur_d   = cur;
    wdog_d  = wdog;
    pulse_d = 1'b0;
    tsrc_d  = timeout_src;
    tcnt_d  = timeout_count;
    tx_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_req = |req;
        if (tx_ack && (|req)) begin
          grant_d = pick_oh;
          cur_d   = pick_idx;
          wdog_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        tx_req = |req;
        wdog_d = wdog + TO_W'(1);
        // done takes priority over a same-cycle watchdog expiry
        if (done[cur]) begin
          grant_d = '0;
          ptr_d   = cur;
          state_d = ST_GAP;
        end else if (WD_EN && wdog == TO_LAST) begin
          grant_d = '0;
          ptr_d   = cur;
          pulse_d = 1'b1;
          tsrc_d  = grant;
          if (timeout_count != 8'hFF) tcnt_d = timeout_count + 8'd1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    tx_data     = '0;
    tx_src_port = '0;
    tx_dst_port = '0;
    tx_length   = '0;
    tx_dst_ip   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        tx_data     |= data[8*i +: 8];
        tx_src_port |= src_port[16*i +: 16];
        tx_dst_port |= dst_port[16*i +: 16];
        tx_length   |= length[16*i +: 16];
        tx_dst_ip   |= dst_ip[32*i +: 32];
      end
    end
  end

  assign tx_start = |(grant & start);
  assign tx_done  = (grant == '0) | (|(grant & done));
  assign tx_stop  = 1'b1;

`ifdef SC_TXARB_STATS_EN
  logic        take;
  logic [15:0] gcnt [N_REQ];

  assign take = (state == ST_IDLE) && tx_ack && (|req);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) gcnt[i] <= '0;
    end else if (take) begin
      for (int i = 0; i < N_REQ; i++)
        if (pick_oh[i] && gcnt[i] != 16'hFFFF)
          gcnt[i] <= gcnt[i] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < N_REQ; i++)
      grant_count[16*i +: 16] = gcnt[i];
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: doc/sc_tx_arbiter.md
Name: sc_tx_arbiter

Overview:
Round-robin arbiter sharing the single UDP transmit interface between N slow-control frame sources: RX error queue, reply queue and decode error queue. It grants one source per frame, muxes that source's header and byte stream onto the UDP TX port, and holds the grant until the source signals done. A watchdog reclaims the interface from a hung source and reports which source it was. Runs in the clk125 domain.

Parameters:
N_REQ, 3, number of requesters; index 0 is the first served after reset.
TO_W, 16, watchdog counter width.
TIMEOUT, 16'hFFFF, cycles in BUSY before forced release; 0 disables the watchdog.

Ports:
clk  in  1  transmit clock (clk125).
rstn  in  1  synchronous active-low reset.
req  in  N_REQ  per-source frame request, level.
done  in  N_REQ  per-source end-of-frame, level.
start  in  N_REQ  per-source start strobe.
data  in  8*N_REQ  per-source byte stream; slice i = [8i+7:8i].
src_port  in  16*N_REQ  per-source UDP source port.
dst_port  in  16*N_REQ  per-source UDP destination port.
dst_ip  in  32*N_REQ  per-source destination IP.
length  in  16*N_REQ  per-source UDP payload length.
grant  out  N_REQ  one-hot grant (the source's txack).
tx_req  out  1  request to the UDP TX engine.
tx_ack  in  1  TX engine ready to accept a new frame.
tx_start, tx_done, tx_stop  out  1  muxed start, muxed done, constant 1.
tx_data  out  8; tx_src_port, tx_dst_port, tx_length  out  16; tx_dst_ip  out  32: muxed fields.
timeout_pulse  out  1  one-cycle pulse on forced release.
timeout_src  out  N_REQ  one-hot source of the last timeout, held.
timeout_count  out  8  saturating count of timeouts.
grant_count  out  16*N_REQ  per-source grant counters (see Optional Feature).

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-low (rstn sampled on the clk rising edge).
- Reset values: state=IDLE, grant=0, ptr=N_REQ-1, wdog=0, timeout_pulse=0, timeout_src=0, timeout_count=0, grant_count=0.
- The mux outputs, tx_start and tx_done are combinational from grant.
- Ungranted outputs: all tx_* fields are 0, tx_start=0, tx_done=1.
- tx_req = OR(req) in IDLE and BUSY; tx_req=0 in GAP.
- State machine (one-hot, states IDLE, BUSY, GAP; illegal encodings recover to IDLE):
  - IDLE: when tx_ack=1 and req!=0, the winner is the first set req bit searching from ptr+1 upward, wrapping modulo N_REQ. Register grant=onehot(winner), clear wdog, go to BUSY. The grant appears on the cycle after tx_ack is sampled. If req=0, stay in IDLE.
  - BUSY: grant is held regardless of req changes; wdog increments each cycle.
    - done[winner]=1: grant<=0, ptr<=winner, go to GAP.
    - Otherwise, TIMEOUT!=0 and wdog==TIMEOUT-1: grant<=0, ptr<=winner, timeout_pulse=1 for one cycle, timeout_src<=winner, timeout_count+1 (saturates at 255), go to GAP.
  - GAP: one cycle with no grant, to let the source deassert done and req. Then go to IDLE.
- Simultaneous done and watchdog expiry in the same cycle: done wins, no timeout is recorded.
- Done from a non-granted source is ignored.
- Busy-to-next-grant latency is at least 2 cycles (GAP, then IDLE sampling tx_ack).
- A source that keeps req high after done is not regranted while other sources are requesting (round-robin fairness).
- Reset asserted mid-frame: return to the reset values at the next edge; the in-flight frame is abandoned.

Optional Feature:
SC_TXARB_STATS_EN defined: grant_count slice i increments (saturating at 16'hFFFF) on each IDLE->BUSY transition that grants source i.
Undefined: no counter logic is built; grant_count is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package sc_pkg holds:
  - state encodings ST_IDLE, ST_BUSY, ST_GAP;
  - the default TIMEOUT constant;
  - the requester index constants SC_REQ_RXERR=0, SC_REQ_RPLY=1, SC_REQ_DECERR=2.
- One sub-module, sc_rr_pick: a combinational round-robin picker with inputs req and ptr, and outputs the one-hot winner and its index.
- The field muxes stay in the top level.

Test Plan:
1. N_REQ=3, TIMEOUT=8. Hold req=3'b101 with tx_ack=1 after reset; each source pulses done 3 cycles after its grant. Required grant sequence: 001, 100, 001, 100. tx_req is 0 on every GAP cycle.
2. All three requesters held high, each done 2 cycles after grant. Required grant order: 001, 010, 100, 001. grant_count reaches {1,1,2} with SC_TXARB_STATS_EN defined and stays 0 without it.
3. Source 1 granted and never asserts done. Required: grant drops after 8 BUSY cycles, timeout_pulse is high for exactly 1 cycle, timeout_src=3'b010, timeout_count=1, and the next grant goes to source 2 if it is requesting.
4. done[1] and watchdog expiry on the same cycle. Required: timeout_pulse stays 0 and timeout_count is unchanged.
5. req=3'b001 with tx_ack=0 for 20 cycles, then tx_ack=1. Required: grant stays 0 throughout and becomes 001 on the cycle after tx_ack rises. Source 0's data=8'hA5 and dst_port=16'h1777 then appear on tx_data and tx_dst_port.
6. rstn=0 for one cycle mid-BUSY. Required: the next cycle shows grant=0, tx_done=1, state=IDLE, and after release the first grant goes to source 0.
